// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer.
// Oversamples an asynchronous rx line and detects start bits. It shifts in
// LSB-first data, checks optional parity and one or two stop bits, and then
// presents each frame on a valid/ready port with per-frame error flags.
module uart_rx_deserializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop_bits2,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS) + 1;

    localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE/2 - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t state, state_nxt;

    logic                 rx_m, rx_s, rx_prev;
    logic [DIV_W-1:0]     div_cnt;
    logic [SAMP_W-1:0]    samp_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 cfg_par_en, cfg_odd, cfg_stop2;
    logic                 perr_acc, ferr_acc;

    logic tick, fall, mid_pt, bit_end;
    logic start_det, start_ok, samp_data, samp_par, samp_stop, complete;

    // A tick is raised on reaching baud_div. The >= keeps the divider from
    // running through its whole range if baud_div is lowered while counting.
    assign tick    = (div_cnt >= baud_div);
    assign fall    = rx_prev & ~rx_s;
    assign mid_pt  = tick && (samp_cnt == SAMP_MID);
    assign bit_end = tick && (samp_cnt == SAMP_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (fall) state_nxt = S_START;
            S_START:  if (mid_pt) state_nxt = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (bit_end && bit_cnt == BIT_LAST)
                          state_nxt = cfg_par_en ? S_PARITY : S_STOP1;
            S_PARITY: if (bit_end) state_nxt = S_STOP1;
            S_STOP1:  if (bit_end) state_nxt = cfg_stop2 ? S_STOP2 : S_IDLE;
            S_STOP2:  if (bit_end) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Per-state strobes that steer the datapath
    always_comb begin
        busy      = (state != S_IDLE);
        start_det = (state == S_IDLE) && fall;
        start_ok  = (state == S_START) && mid_pt;
        samp_data = (state == S_DATA) && bit_end;
        samp_par  = (state == S_PARITY) && bit_end;
        samp_stop = ((state == S_STOP1) || (state == S_STOP2)) && bit_end;
        complete  = bit_end && (((state == S_STOP1) && !cfg_stop2) ||
                                 (state == S_STOP2));
    end

    // Two-flop synchronizer plus edge register; all idle-high after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    // Baud tick divider, realigned to the detected start edge
    always_ff @(posedge clk) begin
        if (rst || start_det || tick) div_cnt <= '0;
        else                          div_cnt <= div_cnt + DIV_W'(1);
    end

    // Sample counter within a bit, and the data bit index
    always_ff @(posedge clk) begin
        if (rst || start_det || start_ok || (busy && bit_end)) samp_cnt <= '0;
        else if (busy && tick)                                 samp_cnt <= samp_cnt + SAMP_W'(1);

        if (rst || start_det) bit_cnt <= '0;
        else if (samp_data)   bit_cnt <= bit_cnt + BIT_W'(1);
    end

    // Frame assembly: config snapshot, shift register, error accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            cfg_par_en <= 1'b0;
            cfg_odd    <= 1'b0;
            cfg_stop2  <= 1'b0;
            perr_acc   <= 1'b0;
            ferr_acc   <= 1'b0;
        end else begin
            if (start_det) begin
                cfg_par_en <= parity_en;
                cfg_odd    <= parity_odd;
                cfg_stop2  <= stop_bits2;
                perr_acc   <= 1'b0;
                ferr_acc   <= 1'b0;
            end
            if (samp_data) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (samp_par)  perr_acc <= (((^shreg) ^ rx_s) != cfg_odd);
            if (samp_stop && !rx_s) ferr_acc <= 1'b1;
        end
    end

    // Output holding register with valid/ready handshake and overrun pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (complete) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg;
                    parity_err <= perr_acc;
                    // The final stop sample is taken this cycle, so fold it in directly.
                    frame_err  <= ferr_acc | ~rx_s;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: table of directed frames, hand-written
// sequences for break/overrun/glitch/latching/reset, and randomized frames
// checked against a parity/stop rule model.
module tb_uart_rx_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic        parity_en, parity_odd, stop_bits2;
    logic        rx;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;
    logic        parity_err, frame_err, overrun_err, busy;

    int errors = 0;
    int checks = 0;
    int ov_cnt = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } cap_t;
    cap_t capq[$];

    typedef struct {
        string      nm;
        logic [7:0] d;
        bit         pen;
        bit         podd;
        bit         pbit;
        bit         s2;
        logic [1:0] stop_v;
        int         bdiv;
        logic [7:0] ed;
        bit         epe;
        bit         efe;
    } vec_t;
    vec_t vecs[8];

    uart_rx_deserializer #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .baud_div(baud_div), .parity_en(parity_en),
        .parity_odd(parity_odd), .stop_bits2(stop_bits2), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .parity_err(parity_err), .frame_err(frame_err),
        .overrun_err(overrun_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Record every accepted frame and every overrun pulse
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            cap_t c;
            c.d = rx_data; c.pe = parity_err; c.fe = frame_err;
            capq.push_back(c);
        end
        if (overrun_err) ov_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic get_cap(input string name, output cap_t c);
        int n = 0;
        while (capq.size() == 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (capq.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: no frame within %0d cycles", name, n);
            c.d = 'x; c.pe = 1'bx; c.fe = 1'bx;
        end else begin
            c = capq.pop_front();
        end
    endtask

    // Drive one frame starting on the next clock; line left at last stop
    // value when idle == 0, otherwise returned high for idle clocks.
    task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit,
                              input int nstop, input logic [1:0] stop_v,
                              input int bclk, input int idle);
        @(posedge clk);
        rx = 1'b0;
        repeat (bclk) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bclk) @(posedge clk);
        end
        if (pen) begin
            rx = pbit;
            repeat (bclk) @(posedge clk);
        end
        for (int i = 0; i < nstop; i++) begin
            rx = stop_v[i];
            repeat (bclk) @(posedge clk);
        end
        if (idle > 0) begin
            rx = 1'b1;
            repeat (idle) @(posedge clk);
        end
    endtask

    initial begin
        cap_t c;
        int   ov0, lat, bclk;
        logic [7:0] rd;
        bit   rpen, rodd, rs2, rpb;
        logic [1:0] rstop;
        int   rbd;
        bit   epe, efe;
        logic [7:0] rst_d;

        vecs[0] = '{"clean_8n1",    8'hA5, 0, 0, 0, 0, 2'b11, 0, 8'hA5, 0, 0};
        vecs[1] = '{"even_par_bad", 8'h5A, 1, 0, 1, 0, 2'b11, 0, 8'h5A, 1, 0};
        vecs[2] = '{"even_par_ok",  8'h5A, 1, 0, 0, 0, 2'b11, 0, 8'h5A, 0, 0};
        vecs[3] = '{"odd_par_ok",   8'h5A, 1, 1, 1, 0, 2'b11, 0, 8'h5A, 0, 0};
        vecs[4] = '{"stop_low",     8'h3C, 0, 0, 0, 0, 2'b00, 0, 8'h3C, 0, 1};
        vecs[5] = '{"slow_div",     8'hFF, 0, 0, 0, 0, 2'b11, 3, 8'hFF, 0, 0};
        vecs[6] = '{"stop2_low",    8'h81, 0, 0, 0, 1, 2'b01, 0, 8'h81, 0, 1};
        vecs[7] = '{"odd_par_bad",  8'h00, 1, 1, 0, 0, 2'b11, 1, 8'h00, 1, 0};

        rst = 1'b1; rx = 1'b1; rx_ready = 1'b1; baud_div = 16'd0;
        parity_en = 1'b0; parity_odd = 1'b0; stop_bits2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_parity_err", parity_err, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_overrun_err", overrun_err, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        repeat (20) @(posedge clk);

        // Directed table
        foreach (vecs[i]) begin
            parity_en = vecs[i].pen; parity_odd = vecs[i].podd;
            stop_bits2 = vecs[i].s2; baud_div = 16'(vecs[i].bdiv);
            bclk = (vecs[i].bdiv + 1) * 16;
            send_frame(vecs[i].d, vecs[i].pen, vecs[i].pbit, vecs[i].s2 ? 2 : 1,
                       vecs[i].stop_v, bclk, 3 * bclk);
            get_cap(vecs[i].nm, c);
            chk({vecs[i].nm, "_data"}, c.d, vecs[i].ed);
            chk({vecs[i].nm, "_perr"}, c.pe, vecs[i].epe);
            chk({vecs[i].nm, "_ferr"}, c.fe, vecs[i].efe);
        end
        @(negedge clk);
        chk("busy_after_table", busy, 0);

        // Start-to-valid latency for 8N1 at baud_div=0: 2 + 8 + 144 + 1 = 155 clocks
        parity_en = 1'b0; stop_bits2 = 1'b0; baud_div = 16'd0;
        lat = 0;
        fork
            send_frame(8'hC3, 0, 0, 1, 2'b11, 16, 48);
            begin
                @(posedge clk);
                while (!rx_valid && lat < 1000) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        get_cap("latency_frame", c);
        chk("latency_data", c.d, 8'hC3);
        chk("latency_in_window", ((lat - 1) >= 154 && (lat - 1) <= 156), 1);

        // Low stop bit followed by a long break: exactly one frame
        send_frame(8'h3C, 0, 0, 1, 2'b00, 16, 0);
        rx = 1'b0;
        repeat (200) @(posedge clk);
        get_cap("break_frame", c);
        chk("break_frame_data", c.d, 8'h3C);
        chk("break_frame_ferr", c.fe, 1);
        chk("break_no_retrigger", capq.size(), 0);
        rx = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("break_release_quiet", capq.size(), 0);
        chk("break_release_busy", busy, 0);
        send_frame(8'h7E, 0, 0, 1, 2'b11, 16, 48);
        get_cap("after_break", c);
        chk("after_break_data", c.d, 8'h7E);

        // Short glitch: false start, no output
        @(posedge clk);
        rx = 1'b0;
        repeat (4) @(posedge clk);
        rx = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("glitch_no_frame", capq.size(), 0);
        chk("glitch_busy", busy, 0);

        // stop_bits2 dropped mid-frame; second stop low still flagged
        stop_bits2 = 1'b1;
        fork
            send_frame(8'h81, 0, 0, 2, 2'b01, 16, 48);
            begin
                @(posedge clk);
                repeat (32) @(posedge clk);
                stop_bits2 = 1'b0;
            end
        join
        get_cap("latch_stop2", c);
        chk("latch_stop2_data", c.d, 8'h81);
        chk("latch_stop2_ferr", c.fe, 1);

        // Overrun with rx_ready low
        rx_ready = 1'b0;
        send_frame(8'h11, 0, 0, 1, 2'b11, 16, 48);
        ov0 = ov_cnt;
        send_frame(8'h22, 0, 0, 1, 2'b11, 16, 48);
        @(negedge clk);
        chk("overrun_pulses", ov_cnt - ov0, 1);
        chk("overrun_held_data", rx_data, 8'h11);
        chk("overrun_held_valid", rx_valid, 1);

        // rx_ready raised exactly on the completion cycle of the third frame
        ov0 = ov_cnt;
        fork
            send_frame(8'h33, 0, 0, 1, 2'b11, 16, 48);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                rx_ready = 1'b1;
                @(posedge clk);
                rx_ready = 1'b0;
            end
        join
        @(negedge clk);
        chk("handoff_data", rx_data, 8'h33);
        chk("handoff_valid", rx_valid, 1);
        chk("handoff_no_overrun", ov_cnt - ov0, 0);
        capq.delete();

        // Reset in the middle of data bit 3 aborts the frame
        rst_d = 8'h96;
        ov0 = ov_cnt;
        @(posedge clk);
        rx = 1'b0;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = rst_d[i];
            repeat (16) @(posedge clk);
        end
        rx = rst_d[3];
        repeat (8) @(posedge clk);
        rst = 1'b1; rx = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", rx_valid, 0);
        chk("midrst_data", rx_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_errs", {parity_err, frame_err, overrun_err}, 0);
        rst = 1'b0;
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk("midrst_quiet_valid", rx_valid, 0);
        chk("midrst_quiet_ov", ov_cnt - ov0, 0);
        rx_ready = 1'b1;
        capq.delete();

        // Randomized frames against the parity/stop rules
        for (int n = 0; n < 30; n++) begin
            rd = 8'($urandom); rpen = 1'($urandom); rodd = 1'($urandom);
            rs2 = 1'($urandom); rpb = 1'($urandom);
            rbd = $urandom_range(0, 2);
            rstop = 2'b11;
            if ($urandom_range(0, 3) == 0) rstop[$urandom_range(0, rs2 ? 1 : 0)] = 1'b0;
            epe = rpen && ((($countones(rd) + rpb) % 2) != rodd);
            efe = (rstop[0] == 1'b0) || (rs2 && rstop[1] == 1'b0);
            parity_en = rpen; parity_odd = rodd; stop_bits2 = rs2;
            baud_div = 16'(rbd);
            bclk = (rbd + 1) * 16;
            send_frame(rd, rpen, rpb, rs2 ? 2 : 1, rstop, bclk, 3 * bclk);
            get_cap($sformatf("rand%0d", n), c);
            chk($sformatf("rand%0d_data", n), c.d, rd);
            chk($sformatf("rand%0d_perr", n), c.pe, epe);
            chk($sformatf("rand%0d_ferr", n), c.fe, efe);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
